// File: rtl/halton_rr_scheduler_if.sv
// Request, configuration and response channels between the requesters/consumer
// and the Halton round-robin scheduler.
interface halton_rr_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_grant;
  logic               cfg_we;
  logic [ID_W-1:0]    cfg_id;
  logic [31:0]        cfg_index;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_x;
  logic [31:0]        rsp_y;

  modport master (
    output req_valid, cfg_we, cfg_id, cfg_index, rsp_ready,
    input  req_grant, rsp_valid, rsp_id, rsp_x, rsp_y
  );

  modport slave (
    input  req_valid, cfg_we, cfg_id, cfg_index, rsp_ready,
    output req_grant, rsp_valid, rsp_id, rsp_x, rsp_y
  );
endinterface

// File: rtl/halton_rr_scheduler.sv
// Round-robin sharing of one reseed/pop Halton core among NUM_REQ requesters,
// each owning a private 32-bit sequence index.
module halton_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  halton_rr_scheduler_if.slave bus,
  output logic                 core_reseed_enable,
  output logic [31:0]          core_seed,
  output logic                 core_pop_enable,
  input  logic [31:0]          core_out_0,
  input  logic [31:0]          core_out_1,
  input  logic                 core_valid
);

  typedef enum logic [2:0] {IDLE, SEED, POP, CAP, RESP} state_t;

  state_t             state, state_nxt;
  logic [31:0]        idx [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr, sel, pick;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [31:0]        rsp_x_q, rsp_y_q;

  function automatic logic [ID_W-1:0] ring_id(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    return ID_W'((32'(base) + off) % NUM_REQ);
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!found && bus.req_valid[ring_id(rr_ptr, off)]) begin
        found = 1'b1;
        pick  = ring_id(rr_ptr, off);
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    grant              = '0;
    core_reseed_enable = 1'b0;
    core_seed          = '0;
    core_pop_enable    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant[pick] = 1'b1;
          state_nxt   = SEED;
        end
      end
      SEED: begin
        core_reseed_enable = 1'b1;
        core_seed          = idx[sel];
        state_nxt          = POP;
      end
      POP: begin
        core_pop_enable = 1'b1;
        state_nxt       = CAP;
      end
      CAP:     if (core_valid) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is a Mealy output of IDLE; mask it so it stays low while in reset.
  assign bus.req_grant = rst_n ? grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_x     = rsp_x_q;
  assign bus.rsp_y     = rsp_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= '0;
      rr_ptr      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) idx[i] <= '0;
    end else begin
      if (state == IDLE && found) begin
        sel    <= pick;
        rr_ptr <= ring_id(pick, 1);
      end
      if (state == CAP && core_valid) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= sel;
        rsp_x_q     <= core_out_0;
        rsp_y_q     <= core_out_1;
        idx[sel]    <= idx[sel] + 32'd1;
      end
      if (state == RESP && bus.rsp_ready) rsp_valid_q <= 1'b0;
      // Placed last so a same-cycle configuration write overrides the CAP increment.
      if (bus.cfg_we) idx[bus.cfg_id] <= bus.cfg_index;
    end
  end

endmodule

// File: tb/tb_halton_rr_scheduler.sv
// Scoreboard bench for halton_rr_scheduler: behavioural Halton core, transaction-level
// reference model predicting grants and points, and a decoupled response monitor.
module tb_halton_rr_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_reseed_enable, core_pop_enable, core_valid;
  logic [31:0] core_seed, core_out_0, core_out_1;

  halton_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  halton_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus),
    .core_reseed_enable (core_reseed_enable),
    .core_seed          (core_seed),
    .core_pop_enable    (core_pop_enable),
    .core_out_0         (core_out_0),
    .core_out_1         (core_out_1),
    .core_valid         (core_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Truncated radical inverse: the low `digits` base-b digits of k mirrored about the point.
  function automatic logic [31:0] rad_inv(input logic [31:0] k, input int unsigned base,
                                          input int unsigned digits);
    logic [31:0] n = k;
    logic [31:0] r = '0;
    for (int unsigned d = 0; d < digits; d++) begin
      r = r * base + n % base;
      n = n / base;
    end
    return r;
  endfunction

  // Behavioural Halton core: reseed loads the counter, pop emits point(counter+1).
  bit          stall_en = 1'b0;
  logic [31:0] core_cnt, pend_x, pend_y;
  int unsigned wait_cnt;

  initial begin : core_model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        core_cnt   <= '0;
        core_valid <= 1'b0;
        core_out_0 <= '0;
        core_out_1 <= '0;
        wait_cnt   <= 0;
      end else begin
        core_valid <= 1'b0;
        if (core_reseed_enable) core_cnt <= core_seed;
        if (core_pop_enable) begin
          core_cnt <= core_cnt + 32'd1;
          if (!stall_en || $urandom_range(0, 3) == 0) begin
            core_valid <= 1'b1;
            core_out_0 <= rad_inv(core_cnt + 32'd1, 2, 11);
            core_out_1 <= rad_inv(core_cnt + 32'd1, 3, 7);
          end else begin
            pend_x   <= rad_inv(core_cnt + 32'd1, 2, 11);
            pend_y   <= rad_inv(core_cnt + 32'd1, 3, 7);
            wait_cnt <= $urandom_range(1, 3);
          end
        end else if (wait_cnt != 0) begin
          wait_cnt <= wait_cnt - 1;
          if (wait_cnt == 1) begin
            core_valid <= 1'b1;
            core_out_0 <= pend_x;
            core_out_1 <= pend_y;
          end
        end
      end
    end
  end

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     x;
    logic [31:0]     y;
    int              gcyc;
  } exp_t;

  exp_t               sb[$];
  exp_t               got[$];
  exp_t               e, g;
  logic [31:0]        m_idx [NUM_REQ];
  int unsigned        m_rr, c;
  bit                 m_busy;
  int                 m_grants = 0;
  int                 cyc = 0;
  logic [NUM_REQ-1:0] exp_g;
  logic [31:0]        k;
  bit                 hold_pending, prev_v;
  logic [ID_W-1:0]    h_id;
  logic [31:0]        h_x, h_y;

  // Reference model + monitor, evaluated mid-cycle on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        for (int unsigned i = 0; i < NUM_REQ; i++) m_idx[i] = '0;
        m_rr = 0;
        m_busy = 1'b0;
        hold_pending = 1'b0;
        prev_v = 1'b0;
      end else begin
        if (bus.cfg_we) m_idx[bus.cfg_id] = bus.cfg_index;
        exp_g = '0;
        if (!m_busy) begin
          for (int unsigned off = 0; off < NUM_REQ; off++) begin
            c = (m_rr + off) % NUM_REQ;
            if (bus.req_valid[c]) begin
              exp_g[c] = 1'b1;
              k        = m_idx[c] + 32'd1;
              e.id     = ID_W'(c);
              e.x      = rad_inv(k, 2, 11);
              e.y      = rad_inv(k, 3, 7);
              e.gcyc   = cyc;
              sb.push_back(e);
              m_idx[c] = k;
              m_rr     = (c + 1) % NUM_REQ;
              m_busy   = 1'b1;
              m_grants++;
              break;
            end
          end
        end
        check("req_grant", 32'(bus.req_grant), 32'(exp_g));
        check("core_both_enables", 32'(core_reseed_enable & core_pop_enable), 0);
        if (!core_reseed_enable) check("core_seed_idle", core_seed, 0);

        if (bus.rsp_valid && !prev_v && !stall_en && sb.size() > 0)
          check("latency", 32'(cyc - sb[0].gcyc), 4);
        if (hold_pending) begin
          check("hold_valid", 32'(bus.rsp_valid), 1);
          check("hold_id", 32'(bus.rsp_id), 32'(h_id));
          check("hold_x", bus.rsp_x, h_x);
          check("hold_y", bus.rsp_y, h_y);
        end
        if (bus.rsp_valid)
          check("core_quiet_in_resp",
                32'(core_reseed_enable) | 32'(core_pop_enable) | core_seed, 0);
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(bus.rsp_valid), 0);
          end else begin
            e = sb.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_x", bus.rsp_x, e.x);
            check("rsp_y", bus.rsp_y, e.y);
          end
          g.id = bus.rsp_id;
          g.x = bus.rsp_x;
          g.y = bus.rsp_y;
          g.gcyc = cyc;
          got.push_back(g);
          m_busy = 1'b0;
        end
        hold_pending = bus.rsp_valid && !bus.rsp_ready;
        h_id = bus.rsp_id;
        h_x = bus.rsp_x;
        h_y = bus.rsp_y;
        prev_v = bus.rsp_valid;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n);
    int target = m_grants + n;
    int t = 0;
    while (m_grants < target && t < 400) begin
      tick(1);
      t++;
    end
    check("grant_wait", 32'(m_grants >= target), 1);
  endtask

  task automatic request(input logic [NUM_REQ-1:0] mask, input int n);
    bus.req_valid = mask;
    wait_grants(n);
    bus.req_valid = '0;
  endtask

  task automatic drain();
    int t = 0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    while (m_busy && t < 100) begin
      tick(1);
      t++;
    end
    tick(1);
    check("drain", 32'(m_busy), 0);
  endtask

  task automatic cfg_write(input logic [ID_W-1:0] id, input logic [31:0] val);
    bus.cfg_we = 1'b1;
    bus.cfg_id = id;
    bus.cfg_index = val;
    tick(1);
    bus.cfg_we = 1'b0;
  endtask

  task automatic check_got(input int i, input logic [ID_W-1:0] id,
                           input logic [31:0] x, input logic [31:0] y);
    if (i < got.size()) begin
      check("log_id", 32'(got[i].id), 32'(id));
      check("log_x", got[i].x, x);
      check("log_y", got[i].y, y);
    end else begin
      check("log_count", 32'(got.size()), 32'(i + 1));
    end
  endtask

  task automatic check_outputs_zero();
    check("zero_req_grant", 32'(bus.req_grant), 0);
    check("zero_rsp_valid", 32'(bus.rsp_valid), 0);
    check("zero_rsp_id", 32'(bus.rsp_id), 0);
    check("zero_rsp_x", bus.rsp_x, 0);
    check("zero_rsp_y", bus.rsp_y, 0);
    check("zero_core_reseed", 32'(core_reseed_enable), 0);
    check("zero_core_seed", core_seed, 0);
    check("zero_core_pop", 32'(core_pop_enable), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n         = 1'b0;
    bus.req_valid = 4'b0001;
    bus.cfg_we    = 1'b0;
    bus.cfg_id    = '0;
    bus.cfg_index = '0;
    bus.rsp_ready = 1'b1;
    tick(3);
    check_outputs_zero();

    // Single requester, three consecutive points.
    got.delete();
    rst_n = 1'b1;
    wait_grants(3);
    drain();
    check_got(0, 0, 1024, 729);
    check_got(1, 0, 512, 1458);
    check_got(2, 0, 1536, 243);

    // All four requesting: round-robin, each gets k=1 then k=2.
    do_reset();
    got.delete();
    request(4'b1111, 8);
    drain();
    for (int i = 0; i < 8; i++)
      check_got(i, ID_W'(i % 4), (i < 4) ? 32'd1024 : 32'd512, (i < 4) ? 32'd729 : 32'd1458);

    // Configure requester 2 while idle.
    got.delete();
    cfg_write(2, 32'd2);
    request(4'b0100, 1);
    drain();
    request(4'b0100, 1);
    drain();
    check_got(0, 2, 1536, 243);
    check_got(1, 2, 256, 972);

    // Consumer back-pressure for 10 cycles with other requests pending.
    bus.rsp_ready = 1'b0;
    request(4'b0011, 1);
    bus.req_valid = 4'b0011;
    for (int t = 0; t < 20 && !bus.rsp_valid; t++) tick(1);
    check("rsp_valid_wait", 32'(bus.rsp_valid), 1);
    tick(10);
    bus.rsp_ready = 1'b1;
    wait_grants(1);
    drain();

    // Index wrap.
    got.delete();
    cfg_write(1, 32'hFFFF_FFFF);
    request(4'b0010, 1);
    drain();
    request(4'b0010, 1);
    drain();
    check_got(0, 1, 0, 0);
    check_got(1, 1, 1024, 729);

    // Configuration write landing on the CAP cycle of the same requester.
    got.delete();
    request(4'b1000, 1);
    tick(2);
    check("cap_core_valid", 32'(core_valid), 1);
    cfg_write(3, 32'd100);
    drain();
    request(4'b1000, 1);
    drain();
    check_got(0, 3, 1536, 243);
    check_got(1, 3, 1328, 1629);

    // Reset in POP: outputs clear at once, index not advanced.
    request(4'b0001, 1);
    tick(1);
    check("pop_phase", 32'(core_pop_enable), 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero();
    tick(2);
    rst_n = 1'b1;
    got.delete();
    request(4'b0001, 1);
    drain();
    check_got(0, 0, 1024, 729);

    // Randomized traffic with core stalls and consumer back-pressure.
    stall_en = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int t = 0; t < 80; t++) begin
        bus.req_valid = NUM_REQ'($urandom);
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
      drain();
      cfg_write(ID_W'($urandom_range(0, NUM_REQ - 1)),
                (b % 2 == 0) ? 32'hFFFF_FFFE : $urandom);
    end
    drain();
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
